// File: rtl/mem_msg_pkg.sv
// Shared definitions for the memory request/response message format used by
// the two-client memory port arbiter.
//
// Request message layout (MSB to LSB):
//   type[4] | opaque[8] | addr[32] | len[clog2(data_nbits/8)] | data[data_nbits]
// Response message layout (MSB to LSB):
//   type[4] | opaque[8] | test[2]  | len[clog2(data_nbits/8)] | data[data_nbits]
//
// Contents: message width functions, field-slice helpers, message type
// encodings and the client ID type used to tag outstanding requests.
package mem_msg_pkg;

  localparam int TYPE_NBITS   = 4;
  localparam int OPAQUE_NBITS = 8;
  localparam int ADDR_NBITS   = 32;
  localparam int TEST_NBITS   = 2;

  localparam logic [TYPE_NBITS-1:0] TYPE_READ     = 4'd0;
  localparam logic [TYPE_NBITS-1:0] TYPE_WRITE    = 4'd1;
  localparam logic [TYPE_NBITS-1:0] TYPE_INIT     = 4'd2;
  localparam logic [TYPE_NBITS-1:0] TYPE_AMO_ADD  = 4'd3;
  localparam logic [TYPE_NBITS-1:0] TYPE_AMO_AND  = 4'd4;
  localparam logic [TYPE_NBITS-1:0] TYPE_AMO_OR   = 4'd5;
  localparam logic [TYPE_NBITS-1:0] TYPE_AMO_SWAP = 4'd6;
  localparam logic [TYPE_NBITS-1:0] TYPE_AMO_MIN  = 4'd7;
  localparam logic [TYPE_NBITS-1:0] TYPE_AMO_MINU = 4'd8;
  localparam logic [TYPE_NBITS-1:0] TYPE_AMO_MAX  = 4'd9;
  localparam logic [TYPE_NBITS-1:0] TYPE_AMO_MAXU = 4'd10;
  localparam logic [TYPE_NBITS-1:0] TYPE_AMO_XOR  = 4'd11;

  // One bit is enough to name the issuing client of a two-way merge.
  typedef logic client_id_t;
  localparam client_id_t CLIENT0 = 1'b0;
  localparam client_id_t CLIENT1 = 1'b1;

  function automatic int len_nbits(input int data_nbits);
    return $clog2(data_nbits / 8);
  endfunction

  function automatic int req_nbits(input int data_nbits);
    return data_nbits + len_nbits(data_nbits) + TYPE_NBITS + OPAQUE_NBITS + ADDR_NBITS;
  endfunction

  function automatic int resp_nbits(input int data_nbits);
    return data_nbits + len_nbits(data_nbits) + TYPE_NBITS + OPAQUE_NBITS + TEST_NBITS;
  endfunction

  // LSB positions of the fields, for consumers that need to slice messages.
  function automatic int req_addr_lsb(input int data_nbits);
    return data_nbits + len_nbits(data_nbits);
  endfunction

  function automatic int req_opaque_lsb(input int data_nbits);
    return req_addr_lsb(data_nbits) + ADDR_NBITS;
  endfunction

  function automatic int resp_opaque_lsb(input int data_nbits);
    return data_nbits + len_nbits(data_nbits) + TEST_NBITS;
  endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order client-ID tracking FIFO for the memory port arbiter.
// Holds one client ID per outstanding memory request; the head names the
// client that owns the next memory response.
//
// Ports:
//   clk        clock, rising edge
//   rst_n_i    asynchronous active-low reset (FIFO becomes empty)
//   push_i     write push_id_i at the tail (ignored when full)
//   push_id_i  client ID to enqueue
//   pop_i      drop the head entry (ignored when empty)
//   head_id_o  client ID at the head (meaningless when empty)
//   full_o     p_depth entries held
//   empty_o    no entries held
//   count_o    number of entries held, 0..p_depth
module mem_arb_id_fifo
  import mem_msg_pkg::*;
#(
  parameter int p_depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  client_id_t               push_id_i,
  input  logic                     pop_i,
  output client_id_t               head_id_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(p_depth):0] count_o
);

  localparam int AW = $clog2(p_depth);

  // Pointers carry one extra MSB so that full and empty are distinguishable
  // when the index bits match.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  client_id_t  mem_q [p_depth];
  logic        do_push, do_pop;

  always_comb begin
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty_o  = (wr_ptr_q == rd_ptr_q);
    count_o  = wr_ptr_q - rd_ptr_q;
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_id_i;
    end
  end

  assign head_id_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/mem_port_arbiter_2to1.sv
// Two-client to one-port memory request arbiter with response steering.
// Requests from client 0 and client 1 are merged round-robin onto a single
// in-order memory port; the ID of each issued request is queued so the
// in-order memory responses can be routed back to their owners. Messages
// pass through untouched and no register sits on either data path.
//
// Ports:
//   clk                       clock, rising edge
//   reset                     asynchronous active-low reset
//   req0_val/rdy/msg          client 0 request stream (in/out/in)
//   resp0_val/rdy/msg         client 0 response stream (out/in/out)
//   req1_*, resp1_*           same for client 1
//   memreq_val/rdy/msg        merged request to memory (out/in/out)
//   memresp_val/rdy/msg       response from memory (in/out/in)
//   inflight                  number of requests awaiting a response
//   proto_err                 sticky: a response arrived with nothing outstanding
module mem_port_arbiter_2to1
  import mem_msg_pkg::*;
#(
  parameter  int p_data_nbits   = 32,
  parameter  int p_max_inflight = 4,
  localparam int REQ_NBITS      = req_nbits(p_data_nbits),
  localparam int RESP_NBITS     = resp_nbits(p_data_nbits),
  localparam int CNT_W          = $clog2(p_max_inflight) + 1
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req0_val,
  output logic                  req0_rdy,
  input  logic [REQ_NBITS-1:0]  req0_msg,
  output logic                  resp0_val,
  input  logic                  resp0_rdy,
  output logic [RESP_NBITS-1:0] resp0_msg,

  input  logic                  req1_val,
  output logic                  req1_rdy,
  input  logic [REQ_NBITS-1:0]  req1_msg,
  output logic                  resp1_val,
  input  logic                  resp1_rdy,
  output logic [RESP_NBITS-1:0] resp1_msg,

  output logic                  memreq_val,
  input  logic                  memreq_rdy,
  output logic [REQ_NBITS-1:0]  memreq_msg,
  input  logic                  memresp_val,
  output logic                  memresp_rdy,
  input  logic [RESP_NBITS-1:0] memresp_msg,

  output logic [CNT_W-1:0]      inflight,
  output logic                  proto_err
);

  client_id_t last_grant_q, last_grant_d;
  logic       proto_err_q, proto_err_d;
  logic       grant0, grant1;
  client_id_t grant_id;
  logic       issue_fire, resp_fire;
  logic       fifo_full, fifo_empty;
  client_id_t head_id;

  mem_arb_id_fifo #(
    .p_depth (p_max_inflight)
  ) u_id_fifo (
    .clk       (clk),
    .rst_n_i   (reset),
    .push_i    (issue_fire),
    .push_id_i (grant_id),
    .pop_i     (resp_fire),
    .head_id_o (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (inflight)
  );

  always_comb begin
    // On a tie, the client that did not win the last issued request goes.
    grant0   = req0_val & (~req1_val | (last_grant_q == CLIENT1));
    grant1   = req1_val & ~grant0;
    grant_id = grant1 ? CLIENT1 : CLIENT0;

    // Full blocks issue even if a response pops this cycle, so there is no
    // combinational path from the response side to the request side.
    // Handshake outputs are also forced low while reset is held.
    memreq_val = reset & (req0_val | req1_val) & ~fifo_full;
    req0_rdy   = reset & grant0 & memreq_rdy & ~fifo_full;
    req1_rdy   = reset & grant1 & memreq_rdy & ~fifo_full;
    memreq_msg = grant1 ? req1_msg : (grant0 ? req0_msg : '0);
    issue_fire = memreq_val & memreq_rdy;

    // Responses only flow while something is outstanding; the FIFO head
    // names the owner.
    resp0_val   = memresp_val & ~fifo_empty & (head_id == CLIENT0);
    resp1_val   = memresp_val & ~fifo_empty & (head_id == CLIENT1);
    resp0_msg   = memresp_msg;
    resp1_msg   = memresp_msg;
    memresp_rdy = ~fifo_empty & ((head_id == CLIENT0) ? resp0_rdy : resp1_rdy);
    resp_fire   = memresp_val & memresp_rdy;

    // A stalled grant keeps last_grant, so the tie order does not rotate.
    last_grant_d = issue_fire ? grant_id : last_grant_q;
    proto_err_d  = proto_err_q | (memresp_val & fifo_empty);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= CLIENT1;
      proto_err_q  <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_port_arbiter_2to1.sv
module tb_mem_port_arbiter_2to1;
  import mem_msg_pkg::*;

  localparam int DW = 32;
  localparam int P  = 4;
  localparam int LW = len_nbits(DW);
  localparam int RQ = req_nbits(DW);
  localparam int RS = resp_nbits(DW);
  localparam int CW = $clog2(P) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_val, req0_rdy, resp0_val, resp0_rdy;
  logic          req1_val, req1_rdy, resp1_val, resp1_rdy;
  logic [RQ-1:0] req0_msg, req1_msg, memreq_msg;
  logic [RS-1:0] resp0_msg, resp1_msg, memresp_msg;
  logic          memreq_val, memreq_rdy, memresp_val, memresp_rdy;
  logic [CW-1:0] inflight;
  logic          proto_err;

  mem_port_arbiter_2to1 #(.p_data_nbits(DW), .p_max_inflight(P)) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
    .inflight(inflight), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state
  logic [31:0]   tbmem [logic [31:0]];
  logic [RS-1:0] exp0_q[$], exp1_q[$];
  logic [RS-1:0] mem_q[$];
  int            own_q[$];
  int            grant_log[$];
  int            issued_n, returned_n;
  int            last_srv;
  bit            exp_perr;
  bit            mon_en = 1'b0;
  bit            acc0 = 1'b0, acc1 = 1'b0;
  logic [7:0]    seq_id = 8'd0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RQ-1:0] gen_req();
    logic [3:0]  t;
    logic [31:0] a, d;
    t = ($urandom_range(1) == 1) ? TYPE_WRITE : TYPE_READ;
    a = 32'h100 + 32'($urandom_range(7)) * 4;
    d = $urandom();
    seq_id = seq_id + 8'd1;
    return {t, seq_id, a, {LW{1'b0}}, d};
  endfunction

  // Memory behaviour: writes store and answer zero data, reads return the
  // stored word (or ~addr for untouched locations).
  function automatic logic [RS-1:0] predict(input logic [RQ-1:0] r);
    logic [3:0]    t;
    logic [7:0]    op;
    logic [31:0]   a, d;
    logic [LW-1:0] ln;
    t  = r[RQ-1 -: 4];
    op = r[RQ-5 -: 8];
    a  = r[RQ-13 -: 32];
    ln = r[DW +: LW];
    if (t == TYPE_WRITE) d = '0;
    else d = tbmem.exists(a) ? tbmem[a] : ~a;
    return {t, op, 2'b00, ln, d};
  endfunction

  function automatic void apply_write(input logic [RQ-1:0] r);
    if (r[RQ-1 -: 4] == TYPE_WRITE) tbmem[r[RQ-13 -: 32]] = r[DW-1:0];
  endfunction

  // Issue-side monitor: checks arbitration, pushes expected responses.
  always @(negedge clk) begin : issue_mon
    int w, a, outn;
    if (!reset) begin
      issued_n <= 0;
      own_q.delete(); mem_q.delete(); exp0_q.delete(); exp1_q.delete();
      last_srv = 1;
    end else if (mon_en) begin
      outn = issued_n - returned_n;
      chk("memreq_val", memreq_val, (req0_val | req1_val) && (outn < P));
      if (req0_val | req1_val) begin
        w = (req0_val && req1_val) ? ((last_srv == 0) ? 1 : 0) : (req0_val ? 0 : 1);
        chk("req0_rdy", req0_rdy, (w == 0) && memreq_rdy && (outn < P));
        chk("req1_rdy", req1_rdy, (w == 1) && memreq_rdy && (outn < P));
        if (outn < P) chk("memreq_msg", memreq_msg, (w == 1) ? req1_msg : req0_msg);
      end else begin
        chk("memreq_msg_idle", memreq_msg, '0);
      end
      if (memreq_val && memreq_rdy) begin
        a = req1_rdy ? 1 : 0;
        if (a == 1) begin exp1_q.push_back(predict(req1_msg)); acc1 = 1'b1; end
        else begin exp0_q.push_back(predict(req0_msg)); acc0 = 1'b1; end
        mem_q.push_back(predict(memreq_msg));
        apply_write(memreq_msg);
        own_q.push_back(a);
        grant_log.push_back(a);
        last_srv = a;
        issued_n <= issued_n + 1;
      end
    end
  end

  // Response-side monitor: pops and compares delivered responses.
  always @(negedge clk) begin : resp_mon
    int outn, h;
    logic [RS-1:0] got;
    if (!reset) begin
      returned_n <= 0;
      exp_perr   <= 1'b0;
    end else if (mon_en) begin
      outn = issued_n - returned_n;
      chk("inflight", inflight, outn);
      chk("proto_err", proto_err, exp_perr);
      if (outn == 0) begin
        chk("resp0_val_idle", resp0_val, 1'b0);
        chk("resp1_val_idle", resp1_val, 1'b0);
        chk("memresp_rdy_idle", memresp_rdy, 1'b0);
        if (memresp_val) exp_perr <= 1'b1;
      end else begin
        h = own_q[0];
        chk("resp0_val", resp0_val, memresp_val && (h == 0));
        chk("resp1_val", resp1_val, memresp_val && (h == 1));
        chk("memresp_rdy", memresp_rdy, (h == 1) ? resp1_rdy : resp0_rdy);
        if (memresp_val && memresp_rdy) begin
          got = (h == 1) ? resp1_msg : resp0_msg;
          void'(own_q.pop_front());
          if (mem_q.size() > 0) void'(mem_q.pop_front());
          if (h == 1) begin
            chk("resp1_pending", exp1_q.size() > 0, 1'b1);
            if (exp1_q.size() > 0) chk("resp1_msg", got, exp1_q.pop_front());
          end else begin
            chk("resp0_pending", exp0_q.size() > 0, 1'b1);
            if (exp0_q.size() > 0) chk("resp0_msg", got, exp0_q.pop_front());
          end
          returned_n <= returned_n + 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  // One cycle of randomized traffic; probabilities are percentages.
  task automatic drive_cycle(input int pn0, input int pn1, input int pmrdy,
                             input int pmresp, input int pcrdy);
    step();
    if (acc0) begin req0_val = 1'b0; acc0 = 1'b0; end
    if (acc1) begin req1_val = 1'b0; acc1 = 1'b0; end
    if (!req0_val && $urandom_range(99) < pn0) begin req0_msg = gen_req(); req0_val = 1'b1; end
    if (!req1_val && $urandom_range(99) < pn1) begin req1_msg = gen_req(); req1_val = 1'b1; end
    memreq_rdy  = ($urandom_range(99) < pmrdy);
    resp0_rdy   = ($urandom_range(99) < pcrdy);
    resp1_rdy   = ($urandom_range(99) < pcrdy);
    memresp_val = (mem_q.size() > 0) && ($urandom_range(99) < pmresp);
    memresp_msg = memresp_val ? mem_q[0] : '0;
  endtask

  initial begin
    logic [RQ-1:0] m;
    logic [63:0]   junk;
    reset = 1'b0;
    req0_val = 1'b1; req1_val = 1'b1; req0_msg = '0; req1_msg = '0;
    resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    memreq_rdy = 1'b1; memresp_val = 1'b1; memresp_msg = '0;
    tbmem[32'h1000] = 32'hDEADBEEF;

    // Reset state
    repeat (2) step();
    chk("rst_memreq_val", memreq_val, 1'b0);
    chk("rst_req0_rdy", req0_rdy, 1'b0);
    chk("rst_req1_rdy", req1_rdy, 1'b0);
    chk("rst_resp0_val", resp0_val, 1'b0);
    chk("rst_resp1_val", resp1_val, 1'b0);
    chk("rst_memresp_rdy", memresp_rdy, 1'b0);
    chk("rst_inflight", inflight, 0);
    chk("rst_proto_err", proto_err, 1'b0);

    // Tie/fairness: both clients valid every cycle
    step();
    reset = 1'b1; memresp_val = 1'b0; mon_en = 1'b1;
    req0_msg = gen_req(); req1_msg = gen_req();
    grant_log.delete();
    repeat (5) drive_cycle(100, 100, 100, 100, 100);
    repeat (20) drive_cycle(0, 0, 100, 100, 100);
    chk("fair_count", grant_log.size() >= 6, 1'b1);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk($sformatf("fair_grant%0d", i), grant_log[i], i % 2);

    // Single client read
    step();
    resp0_rdy = 1'b1; resp1_rdy = 1'b1; memreq_rdy = 1'b1; memresp_val = 1'b0;
    req0_msg = {TYPE_READ, 8'h05, 32'h1000, {LW{1'b0}}, 32'h0}; req0_val = 1'b1;
    sample();
    chk("single_memreq_val", memreq_val, 1'b1);
    chk("single_req0_rdy", req0_rdy, 1'b1);
    step();
    req0_val = 1'b0; acc0 = 1'b0;
    memresp_val = 1'b1; memresp_msg = mem_q[0];
    sample();
    chk("single_inflight1", inflight, 1);
    chk("single_resp0_val", resp0_val, 1'b1);
    chk("single_resp0_data", resp0_msg[DW-1:0], 32'hDEADBEEF);
    chk("single_resp0_opaque", resp0_msg[RS-5 -: 8], 8'h05);
    chk("single_resp1_val", resp1_val, 1'b0);
    step();
    memresp_val = 1'b0;
    sample();
    chk("single_inflight0", inflight, 0);

    // Full stall: no responses until four are outstanding
    repeat (5) drive_cycle(100, 0, 100, 0, 100);
    sample();
    chk("full_inflight", inflight, P);
    chk("full_memreq_val", memreq_val, 1'b0);
    chk("full_req0_rdy", req0_rdy, 1'b0);
    step();
    memresp_val = 1'b1; memresp_msg = mem_q[0];
    sample();
    chk("full_pop_memresp_rdy", memresp_rdy, 1'b1);
    chk("full_pop_memreq_val", memreq_val, 1'b0);
    chk("full_pop_req0_rdy", req0_rdy, 1'b0);
    step();
    memresp_val = 1'b0;
    sample();
    chk("full_resume_inflight", inflight, P - 1);
    chk("full_resume_memreq_val", memreq_val, 1'b1);
    chk("full_resume_req0_rdy", req0_rdy, 1'b1);
    repeat (20) drive_cycle(0, 0, 100, 100, 100);

    // Response backpressure with client 1 at the head
    step();
    memreq_rdy = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b0; memresp_val = 1'b0;
    req1_msg = gen_req(); req1_val = 1'b1;
    sample();
    step();
    req1_val = 1'b0; acc1 = 1'b0;
    req0_msg = gen_req(); req0_val = 1'b1;
    sample();
    step();
    req0_val = 1'b0; acc0 = 1'b0;
    memresp_val = 1'b1; memresp_msg = mem_q[0];
    sample();
    chk("bp_memresp_rdy_held", memresp_rdy, 1'b0);
    chk("bp_resp1_val", resp1_val, 1'b1);
    chk("bp_resp0_val", resp0_val, 1'b0);
    chk("bp_inflight", inflight, 2);
    step();
    sample();
    chk("bp_memresp_rdy_held2", memresp_rdy, 1'b0);
    chk("bp_inflight2", inflight, 2);
    step();
    resp1_rdy = 1'b1;
    sample();
    chk("bp_memresp_rdy_release", memresp_rdy, 1'b1);
    step();
    memresp_msg = mem_q[0];
    sample();
    chk("bp_resp0_val_after", resp0_val, 1'b1);
    chk("bp_resp1_val_after", resp1_val, 1'b0);
    chk("bp_inflight_after", inflight, 1);
    step();
    memresp_val = 1'b0;
    sample();
    chk("bp_inflight_done", inflight, 0);

    // Randomized mixed traffic
    repeat (800) drive_cycle(50, 50, 70, 60, 70);
    repeat (40) drive_cycle(0, 0, 100, 100, 100);
    sample();
    chk("rand_exp0_drained", exp0_q.size(), 0);
    chk("rand_exp1_drained", exp1_q.size(), 0);
    chk("rand_inflight_drained", inflight, 0);

    // Reset mid-flight with three outstanding
    repeat (3) drive_cycle(100, 0, 100, 0, 100);
    step();
    req0_val = 1'b0; acc0 = 1'b0;
    sample();
    chk("mid_inflight3", inflight, 3);
    @(posedge clk); #3;
    mon_en = 1'b0;
    req0_msg = gen_req(); req0_val = 1'b1;
    req1_msg = gen_req(); req1_val = 1'b1;
    memresp_val = 1'b1; memresp_msg = '0;
    reset = 1'b0;
    #1;
    chk("mid_inflight0", inflight, 0);
    chk("mid_memreq_val", memreq_val, 1'b0);
    chk("mid_req0_rdy", req0_rdy, 1'b0);
    chk("mid_resp0_val", resp0_val, 1'b0);
    chk("mid_resp1_val", resp1_val, 1'b0);
    chk("mid_memresp_rdy", memresp_rdy, 1'b0);
    step(); #1;
    memresp_val = 1'b0; memreq_rdy = 1'b1; acc0 = 1'b0; acc1 = 1'b0;
    reset = 1'b1; mon_en = 1'b1;
    m = req0_msg;
    sample();
    chk("post_rst_req0_rdy", req0_rdy, 1'b1);
    chk("post_rst_req1_rdy", req1_rdy, 1'b0);
    chk("post_rst_memreq_msg", memreq_msg, m);
    repeat (20) drive_cycle(0, 0, 100, 100, 100);

    // Protocol error: response with nothing outstanding
    step();
    junk = {$urandom(), $urandom()};
    memresp_val = 1'b1; memresp_msg = junk[RS-1:0];
    sample();
    chk("perr_memresp_rdy", memresp_rdy, 1'b0);
    chk("perr_resp0_val", resp0_val, 1'b0);
    chk("perr_resp1_val", resp1_val, 1'b0);
    chk("perr_not_yet", proto_err, 1'b0);
    step();
    memresp_val = 1'b0;
    sample();
    chk("perr_set", proto_err, 1'b1);
    repeat (5) drive_cycle(60, 60, 100, 100, 100);
    repeat (20) drive_cycle(0, 0, 100, 100, 100);
    sample();
    chk("perr_sticky", proto_err, 1'b1);
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("perr_cleared", proto_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter_2to1.md
Name: mem_port_arbiter_2to1

Overview:
- Merges two independent client memory-request streams (e.g. core dmem and accelerator) onto the single in-order data port of the test memory, then routes its responses back to the issuing client.
- Round-robin arbitration; an in-order client-ID tracking FIFO steers responses. Request/response message fields pass through unmodified.
- Sits directly upstream of the test memory's dmem port and consumes its response stream.

Parameters:
- p_data_nbits, 32, data field width of the request/response messages (multiple of 8, ≥16)
- p_max_inflight, 4, maximum outstanding requests; tracking FIFO depth (power of 2, ≥2)
- Derived: REQ_NBITS = p_data_nbits + clog2(p_data_nbits/8) + 44 (78 at default); RESP_NBITS = p_data_nbits + clog2(p_data_nbits/8) + 14 (48 at default)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- req0_val / req0_rdy  in / out  1 / 1  client 0 request handshake
- req0_msg  in  REQ_NBITS  client 0 request {type[4], opaque[8], addr[32], len, data}
- resp0_val / resp0_rdy  out / in  1 / 1  client 0 response handshake
- resp0_msg  out  RESP_NBITS  client 0 response
- req1_val, req1_rdy, req1_msg, resp1_val, resp1_rdy, resp1_msg  same as client 0, for client 1
- memreq_val / memreq_rdy  out / in  1 / 1  request to memory
- memreq_msg  out  REQ_NBITS  granted request
- memresp_val / memresp_rdy  in / out  1 / 1  response from memory
- memresp_msg  in  RESP_NBITS  memory response
- inflight  out  clog2(p_max_inflight)+1  outstanding request count
- proto_err  out  1  sticky: memory response arrived with nothing outstanding

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, inflight=0, proto_err=0, last_grant=1 (client 0 wins first tie). All val/rdy outputs 0 while reset is asserted.
- Grant, combinational:
  - Only one client valid → that client is granted.
  - Both valid → the client that is not last_grant is granted.
- Issue:
  - memreq_val = (req0_val | req1_val) & !full.
  - memreq_msg = granted client's msg (all-zero when neither client is valid).
  - reqN_rdy = grantN & memreq_rdy & !full.
  - The non-granted client's rdy is 0.
- Issue fire (memreq_val & memreq_rdy):
  - Push the granted client ID into the tail of the FIFO.
  - last_grant <= granted ID.
  - last_grant is unchanged when no fire occurs, so a stalled grant does not rotate.
- full = (inflight == p_max_inflight). full blocks issue even if a pop happens in the same cycle; there is no bypass, which keeps timing to memory free of a resp→req combinational path.
- Response routing, combinational, head = FIFO head ID:
  - respN_val = memresp_val & !empty & (head==N).
  - respN_msg = memresp_msg for both clients (qualified by val).
  - memresp_rdy = !empty & resp[head]_rdy.
- Response fire (memresp_val & memresp_rdy): pop the FIFO head.
- Simultaneous push and pop (not full): inflight unchanged; the pointers both advance.
- Pointers wrap modulo p_max_inflight. An extra MSB distinguishes full from empty.
- memresp_val while empty:
  - memresp_rdy=0 and no respN_val.
  - proto_err <= 1, held until reset.
- Latency: zero-cycle combinational pass-through on both paths; the arbiter adds no registers in the data path. Throughput is 1 request/cycle.
- Reset asserted mid-operation: outstanding responses are forgotten. The memory side must be reset in the same window.
- Any response arriving later is handled as in the empty case above (proto_err).

Decomposition:
- Shared package `mem_msg_pkg`:
  - msg width functions REQ_NBITS/RESP_NBITS;
  - field-slice constants;
  - TYPE_* encodings (READ=0 … AMO_XOR=11);
  - client ID typedef.
- One sub-module, `mem_arb_id_fifo`: parameterised-depth, 1-bit-wide synchronous FIFO with full/empty/count outputs and async active-low reset. Arbitration and steering logic live in the top module.

Test Plan:
- Single client: client 0 issues read addr 0x1000, opaque 0x05; memory returns data 0xDEADBEEF next cycle → resp0 carries 0xDEADBEEF with opaque 0x05; resp1_val stays 0; inflight goes 1→0.
- Tie/fairness: both clients hold val for 6 cycles with memreq_rdy=1 → grants alternate 0,1,0,1,0,1; responses return to matching clients in issue order.
- Full stall: memresp_val held 0; 4 requests issue → inflight=4, memreq_val=0, req rdy=0 on the 5th. In the cycle one response pops, still no issue; issue resumes the following cycle.
- Response backpressure: head=client 1 and resp1_rdy=0 → memresp_rdy=0 and the response is held. When resp1_rdy is raised → popped; client 0's later response is not delivered first.
- Protocol error: after reset, memresp_val=1 with nothing outstanding → memresp_rdy=0, proto_err=1, and it stays 1 until reset.
- Reset mid-flight: with 3 outstanding, assert reset asynchronously (mid-cycle) → inflight=0 and all val outputs 0 immediately. After release, client 0 wins the first tie.
